// File: rtl/seu_if.sv
// Bundle between the instruction decoder (master) and the sign/zero-extension unit (slave).
// Carries the raw immediate, the mode selects, and the registered extended result.
interface seu_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic [IN_W-1:0]  inmediate;
  logic             seu_en;
  logic             lui_en;
  logic             sh2_en;
  logic             in_valid;
  logic [OUT_W-1:0] inm_ext;
  logic             out_valid;

  modport master (
    output inmediate, seu_en, lui_en, sh2_en, in_valid,
    input  inm_ext, out_valid
  );

  modport slave (
    input  inmediate, seu_en, lui_en, sh2_en, in_valid,
    output inm_ext, out_valid
  );
endinterface

// File: rtl/seu.sv
// Sign/zero-extension unit: widens the instruction immediate to datapath width,
// with load-upper and branch word-offset modes, registered with one cycle of latency.
module seu #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  seu_if.slave bus
);

  localparam int EXT_W = OUT_W - IN_W;

  // The shift-by-2 path only keeps the sign if at least two replicated bits exist above the immediate.
  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("seu: OUT_W must be at least IN_W + 2");
  end

  function automatic logic signed [OUT_W-1:0] extend(
    input logic [IN_W-1:0] imm,
    input logic            sext
  );
    logic fill;
    fill = sext & imm[IN_W-1];
    return {{EXT_W{fill}}, imm};
  endfunction

  function automatic logic signed [OUT_W-1:0] place_upper(
    input logic [IN_W-1:0] imm
  );
    return {imm, {EXT_W{1'b0}}};
  endfunction

  function automatic logic signed [OUT_W-1:0] shift_word(
    input logic signed [OUT_W-1:0] val
  );
    return {val[OUT_W-3:0], 2'b00};
  endfunction

  logic signed [OUT_W-1:0] ext_p0;
  logic signed [OUT_W-1:0] ext_p1_d, ext_p1_q;
  logic                    vld_p1_d, vld_p1_q;

  always_comb begin
    ext_p0 = extend(bus.inmediate, bus.seu_en);
    if (bus.lui_en) begin
      ext_p0 = place_upper(bus.inmediate);
    end else if (bus.sh2_en) begin
      ext_p0 = shift_word(ext_p0);
    end
  end

  always_comb begin
    ext_p1_d = ext_p1_q;
    vld_p1_d = bus.in_valid;
    if (bus.in_valid) begin
      ext_p1_d = ext_p0;
    end
  end

  // p0 -> p1: result register, cleared asynchronously so reset never exposes a partial value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      ext_p1_q <= ext_p1_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  assign bus.inm_ext   = ext_p1_q;
  assign bus.out_valid = vld_p1_q;

endmodule

// File: tb/tb_seu.sv
// Directed bench for seu: reset behaviour, extension modes, shift, LUI override,
// hold on invalid input and asynchronous reset mid-stream.
module tb_seu;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seu_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  seu #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs_ext, input logic obs_vld,
                     input logic [OUT_W-1:0] exp_ext, input logic exp_vld);
    checks++;
    assert (obs_ext === exp_ext) else begin
      errors++;
      $error("FAIL %s inm_ext observed %h expected %h", tag, obs_ext, exp_ext);
    end
    checks++;
    assert (obs_vld === exp_vld) else begin
      errors++;
      $error("FAIL %s out_valid observed %b expected %b", tag, obs_vld, exp_vld);
    end
  endtask

  task automatic drive(input logic [IN_W-1:0] imm, input logic s, input logic l,
                       input logic h, input logic v);
    bus.inmediate = imm;
    bus.seu_en    = s;
    bus.lui_en    = l;
    bus.sh2_en    = h;
    bus.in_valid  = v;
  endtask

  task automatic step(input string tag, input logic [IN_W-1:0] imm, input logic s,
                      input logic l, input logic h, input logic v,
                      input logic [OUT_W-1:0] exp_ext, input logic exp_vld);
    drive(imm, s, l, h, v);
    @(posedge clk);
    #1;
    chk(tag, bus.inm_ext, bus.out_valid, exp_ext, exp_vld);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);

    #1;
    chk("reset_t0", bus.inm_ext, bus.out_valid, 32'h0000_0000, 1'b0);
    @(posedge clk); #1;
    chk("reset_edge1", bus.inm_ext, bus.out_valid, 32'h0000_0000, 1'b0);
    @(posedge clk); #1;
    chk("reset_edge2", bus.inm_ext, bus.out_valid, 32'h0000_0000, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("reset_release", bus.inm_ext, bus.out_valid, 32'h0000_0000, 1'b0);

    step("small_pos_sext", 16'h000F, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_000F, 1'b1);
    step("small_pos_zext", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000F, 1'b1);
    step("neg_sext",       16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_8000, 1'b1);
    step("neg_zext",       16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_8000, 1'b1);
    step("branch_neg",     16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    step("branch_pos",     16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1);
    step("shift_zext",     16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0002_0000, 1'b1);
    step("lui_override",   16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_0000, 1'b1);
    step("lui_all_ones",   16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_0000, 1'b1);
    step("capture_7fff",   16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_7FFF, 1'b1);
    step("hold_1",         16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7FFF, 1'b0);
    step("hold_2",         16'h8001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_7FFF, 1'b0);
    step("hold_3",         16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_7FFF, 1'b0);
    step("recapture",      16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b1);

    rst_n = 1'b0;
    #1;
    chk("midstream_reset", bus.inm_ext, bus.out_valid, 32'h0000_0000, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("after_pulse", bus.inm_ext, bus.out_valid, 32'h0000_0000, 1'b0);

    step("post_reset_idle", 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    step("post_reset_cap",  16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
